// File: rtl/dup_rle.sv
// dup_rle: run-length encoder stage for generator-style value streams.
// Consumes a valid/ready stream of signed values and emits (value, run-length)
// pairs through a single-entry output register with valid/ready handshake.
//
// Ports:
//   _clock    rising-edge clock
//   _reset    asynchronous active-low reset
//   _start    one-cycle pulse: abort any activity and begin a new stream
//   _ready    downstream accepts the current output pair
//   in_valid  upstream value valid
//   in_done   upstream stream finished
//   in_0      upstream signed value
//   in_ready  this stage accepts an upstream value
//   _valid    output pair valid
//   _done     stream fully encoded and drained
//   _0        run value (signed)
//   _1        run length, 1 .. 2^CW-1
module dup_rle #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic                    _ready,
  input  logic                    in_valid,
  input  logic                    in_done,
  input  logic signed [WIDTH-1:0] in_0,
  output logic                    in_ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic        [CW-1:0]    _1
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                  state,     state_nx;
  logic                    run_open,  run_open_nx;
  logic signed [WIDTH-1:0] run_val,   run_val_nx;
  logic        [CW-1:0]    run_cnt,   run_cnt_nx;
  logic                    out_valid, out_valid_nx;
  logic signed [WIDTH-1:0] out_val,   out_val_nx;
  logic        [CW-1:0]    out_cnt,   out_cnt_nx;

  logic out_free;
  logic consume;
  logic accept;
  logic cnt_max;
  logic same_val;

  // Output register can take a new pair if empty or being drained this cycle.
  assign out_free = !out_valid || _ready;
  assign consume  = out_valid && _ready;
  assign in_ready = (state == RUN) && out_free;
  assign accept   = in_valid && in_ready;
  assign cnt_max  = (run_cnt == '1);
  assign same_val = (in_0 == run_val);

  assign _valid = out_valid;
  assign _done  = (state == DONE);
  assign _0     = out_val;
  assign _1     = out_cnt;

  always_comb begin
    state_nx     = state;
    run_open_nx  = run_open;
    run_val_nx   = run_val;
    run_cnt_nx   = run_cnt;
    out_valid_nx = out_valid;
    out_val_nx   = out_val;
    out_cnt_nx   = out_cnt;

    // A consumed pair clears the register; a load in the same cycle overrides
    // this below, giving back-to-back pairs without a bubble.
    if (consume) begin
      out_valid_nx = 1'b0;
    end

    if (_start) begin
      state_nx     = RUN;
      run_open_nx  = 1'b0;
      run_cnt_nx   = '0;
      out_valid_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
        end

        RUN: begin
          if (accept) begin
            // Run ends on a different value or on a saturated counter.
            if (run_open && (!same_val || cnt_max)) begin
              out_valid_nx = 1'b1;
              out_val_nx   = run_val;
              out_cnt_nx   = run_cnt;
            end
            if (run_open && same_val && !cnt_max) begin
              run_cnt_nx = run_cnt + 1'b1;
            end else begin
              run_open_nx = 1'b1;
              run_val_nx  = in_0;
              run_cnt_nx  = CW'(1);
            end
          end
          if (in_done) begin
            state_nx = FLUSH;
          end
        end

        FLUSH: begin
          if (run_open) begin
            if (out_free) begin
              out_valid_nx = 1'b1;
              out_val_nx   = run_val;
              out_cnt_nx   = run_cnt;
              run_open_nx  = 1'b0;
              run_cnt_nx   = '0;
            end
          end else if (out_free) begin
            state_nx = DONE;
          end
        end

        DONE: begin
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      run_open  <= 1'b0;
      run_val   <= '0;
      run_cnt   <= '0;
      out_valid <= 1'b0;
      out_val   <= '0;
      out_cnt   <= '0;
    end else begin
      state     <= state_nx;
      run_open  <= run_open_nx;
      run_val   <= run_val_nx;
      run_cnt   <= run_cnt_nx;
      out_valid <= out_valid_nx;
      out_val   <= out_val_nx;
      out_cnt   <= out_cnt_nx;
    end
  end

endmodule

// File: doc/dup_rle.md
Name: dup_rle

Overview:
- Downstream consumer stage for range-style generator blocks (for example, a duplicating range generator that yields each value twice).
- Accepts the producer's valid/ready value stream and collapses runs of consecutive equal values into (value, run-length) pairs.
- Exposes the same generator-style handshake as the producers (_start/_ready/_valid/_done), so it can feed further stages or a bench directly.
- Bridges upstream back-pressure through a single-entry output register.

Parameters:
WIDTH, 32, width of signed data values
CW, 8, width of unsigned run-length counter; maximum run length 2^CW-1

Ports:
_clock  input  1  system clock, rising edge
_reset  input  1  reset, asynchronous, active-low
_start  input  1  one-cycle pulse: clear state and begin consuming a new stream
_ready  input  1  downstream ready to accept output pair
in_valid  input  1  upstream data valid (producer's _valid)
in_done  input  1  upstream stream finished (producer's _done)
in_0  input  WIDTH  upstream signed data (producer's _0)
in_ready  output  1  this block accepts upstream data (drives producer's _ready)
_valid  output  1  output pair valid
_done  output  1  stream fully encoded and drained
_0  output  WIDTH  signed run value
_1  output  CW  run length (>=1 whenever _valid)

Behaviour:
- Interface: one clock, _clock. Reset is asynchronous and active-low on port _reset.
- While _reset=0: state=IDLE; in_ready=0, _valid=0, _done=0, _0=0, _1=0; run register empty, count=0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0, _done=0. _start=1 -> RUN.
- _start=1 in any non-reset state: aborts, discards open run and output register (_valid->0), enters RUN next cycle. This takes priority over all other events.
- Upstream accept: a value is accepted when in_valid && in_ready at the rising edge.
- in_ready = (state==RUN) && (!_valid || _ready).
- Output handshake: a pair is consumed when _valid && _ready. _0/_1 hold stable while _valid && !_ready.
- Accepted value x, no open run: open run (val=x, cnt=1). Nothing is emitted.
- Accepted value x == val (full signed WIDTH compare) and cnt < 2^CW-1: cnt++.
- Accepted value x == val and cnt == 2^CW-1 (saturation): emit (val, 2^CW-1), then open new run (x, 1).
- Accepted value x != val: emit (val, cnt), then open run (x, 1).
- Emit: the output register loads at the same edge as the accept, so _valid is high the next cycle. Latency is 1 cycle from the accept of the run-terminating value.
- Simultaneous consume and load in one cycle is legal; the new pair replaces the old one with no bubble.
- in_done sampled high in RUN -> FLUSH. If in_valid is also high and in_ready=1 in that cycle, the value is accepted first.
- FLUSH: in_ready=0. Open run present -> emit it once the output register is free (!_valid || _ready), then wait for drain. When _valid=0 (or is being consumed) and no run is open -> DONE.
- No values accepted before in_done: no pairs emitted; goes straight to DONE.
- DONE: _done=1, _valid=0, in_ready=0. Holds until _start or reset.
- Reset asserted mid-stream: all state is cleared asynchronously, and any pending pair is dropped.
- Counter never wraps. Runs longer than 2^CW-1 split into consecutive pairs with the same _0.

Test Plan:
- Upstream stream 0,0,2,2,4,4,6,6,8,8 then in_done, _ready=1 -> pairs (0,2),(2,2),(4,2),(6,2),(8,2) in order, then _done=1 with _valid=0.
- Stream 5,5,5,-3,-3,7 with the last value accepted in the same cycle as in_done -> (5,3),(-3,2),(7,1), _done=1. Confirms signed compare and the same-cycle done accept.
- CW=2, stream of seven 9s -> (9,3),(9,3),(9,1). Confirms saturation split with no lost count.
- _ready held 0 for 5 cycles while pairs pend -> in_ready drops, _0/_1 stay stable, no value is lost. Output resumes in order after _ready=1.
- in_done with no prior values -> _done=1 within 2 cycles, no _valid pulse.
- _reset pulsed low mid-stream, then _start, then stream 1,1 + in_done -> all outputs 0 during reset, then only (1,2) emitted and _done=1. Repeat using _start mid-stream instead of reset; expect the same clean result.
